// File: rtl/sample_flow_ctrl.sv
// -----------------------------------------------------------------------------
// sample_flow_ctrl
//
// Flow controller and sample ring buffer sitting between the word
// deserializer (producer, fed by the Raspberry Pi) and the I2S transmitter
// (consumer).
//
// The buffer holds DEPTH words. Playback starts only once PREFILL words are
// buffered. Every transmitter request is answered exactly one cycle later.
// A request that finds the buffer empty while playing is an underrun. The
// RPi refill interrupt uses low/high watermark hysteresis.
//
// Ports:
//   clk            system clock, all logic on its rising edge
//   reset_n        synchronous active-low reset
//   enable         playback enable; low flushes the buffer and forces IDLE
//   in_valid       producer word valid
//   in_data        producer word
//   in_ready       buffer can accept a word (not full and enabled)
//   out_req        single-cycle sample request from the I2S transmitter
//   out_valid      single-cycle response strobe, one cycle after out_req
//   out_data       returned sample (zero when no real data is available)
//   rpi_interrupt  asks the RPi for more data
//   level          words currently buffered (0..DEPTH)
//   underrun_count saturating underrun counter, cleared only by reset
//   state          0 = IDLE, 1 = PLAY, 2 = UNDERRUN
// -----------------------------------------------------------------------------
module sample_flow_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LOW_WM     = 16,
    parameter int unsigned HIGH_WM    = 48,
    parameter int unsigned PREFILL    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    input  logic                  out_req,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  rpi_interrupt,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            underrun_count,
    output logic [1:0]            state
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_UNDERRUN = 2'd2;

    localparam logic [DEPTH_LOG2:0] LVL_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_LOW     = (DEPTH_LOG2 + 1)'(LOW_WM);
    localparam logic [DEPTH_LOG2:0] LVL_HIGH    = (DEPTH_LOG2 + 1)'(HIGH_WM);
    localparam logic [DEPTH_LOG2:0] LVL_PREFILL = (DEPTH_LOG2 + 1)'(PREFILL);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    logic                  underrun_hit;

    assign in_ready = (level != LVL_FULL) && enable;
    assign wr_en    = in_valid && in_ready;

    // Reads and underruns are mutually exclusive: both need PLAY and an
    // enabled block, and split on whether the registered level is zero. A
    // write in the same cycle never rescues an empty buffer.
    assign rd_en        = out_req && enable && (state == ST_PLAY) && (level != '0);
    assign underrun_hit = out_req && enable && (state == ST_PLAY) && (level == '0);

    // Buffer storage carries no reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            rpi_interrupt  <= 1'b0;
            underrun_count <= '0;
            state          <= ST_IDLE;
        end else begin
            // Every request gets exactly one response, whatever the state.
            out_valid <= out_req;
            if (out_req) begin
                out_data <= rd_en ? mem[rd_ptr] : '0;
            end

            if (!enable) begin
                // Flush: in_ready is already low so no write is lost here.
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level         <= '0;
                rpi_interrupt <= 1'b0;
                state         <= ST_IDLE;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end

                case ({wr_en, rd_en})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase

                // Hysteresis: set below LOW_WM, clear at HIGH_WM, hold between.
                if (level >= LVL_HIGH) begin
                    rpi_interrupt <= 1'b0;
                end else if (level < LVL_LOW) begin
                    rpi_interrupt <= 1'b1;
                end

                if (underrun_hit && (underrun_count != 8'hFF)) begin
                    underrun_count <= underrun_count + 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (level >= LVL_PREFILL) begin
                            state <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (underrun_hit) begin
                            state <= ST_UNDERRUN;
                        end
                    end
                    ST_UNDERRUN: begin
                        if (level >= LVL_PREFILL) begin
                            state <= ST_PLAY;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sample_flow_ctrl
//
// Drives sample_flow_ctrl through a directed walk (prefill, ordered drain,
// underrun, full/wrap, simultaneous traffic, mid-stream disable, counter
// saturation) followed by randomized traffic. Expected values come from a
// queue-based model of the buffer kept in this file.
// -----------------------------------------------------------------------------
module tb_sample_flow_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned DL = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_req;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          rpi_interrupt;
    logic [DL:0]   level;
    logic [7:0]    underrun_count;
    logic [1:0]    state;

    sample_flow_ctrl #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DL),
        .LOW_WM     (16),
        .HIGH_WM    (48),
        .PREFILL    (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_req        (out_req),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .rpi_interrupt  (rpi_interrupt),
        .level          (level),
        .underrun_count (underrun_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the buffer is a queue, level is its size.
    logic [W-1:0] m_q[$];
    int           m_state;   // 0 IDLE, 1 PLAY, 2 UNDERRUN
    bit           m_irq;
    int           m_cnt;
    bit           m_ov;
    logic [W-1:0] m_od;
    logic [W-1:0] seq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_irq   = 1'b0;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_od    = '0;
    endtask

    task automatic model_step(input bit en, input bit v, input logic [W-1:0] d, input bit req);
        int lvl;
        lvl  = m_q.size();
        m_ov = req;
        if (!en) begin
            if (req) m_od = '0;
            m_q.delete();
            m_state = 0;
            m_irq   = 1'b0;
        end else begin
            if (req) begin
                if (m_state == 1 && lvl > 0) m_od = m_q.pop_front();
                else m_od = '0;
            end
            if (v && lvl < 64) m_q.push_back(d);
            if (lvl >= 48) m_irq = 1'b0;
            else if (lvl < 16) m_irq = 1'b1;
            case (m_state)
                0: if (lvl >= 32) m_state = 1;
                1: if (req && lvl == 0) begin
                       m_state = 2;
                       if (m_cnt < 255) m_cnt++;
                   end
                default: if (lvl >= 32) m_state = 1;
            endcase
        end
    endtask

    task automatic compare_outputs();
        check("level", 32'(level), 32'(m_q.size()));
        check("state", 32'(state), 32'(m_state));
        check("rpi_interrupt", 32'(rpi_interrupt), 32'(m_irq));
        check("underrun_count", 32'(underrun_count), 32'(m_cnt));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
    endtask

    // One clock cycle with the given inputs; called at posedge+1.
    task automatic step(input bit en, input bit v, input logic [W-1:0] d, input bit req);
        reset_n  = 1'b1;
        enable   = en;
        in_valid = v;
        in_data  = d;
        out_req  = req;
        #1;
        check("in_ready", 32'(in_ready), 32'(en && m_q.size() < 64));
        @(posedge clk);
        model_step(en, v, d, req);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset_n  = 1'b0;
            enable   = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            out_req  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        model_reset();
        compare_outputs();
    endtask

    task automatic wr(input int n);
        for (int i = 0; i < n; i++) begin
            seq = seq + 1'b1;
            step(1'b1, 1'b1, seq, 1'b0);
        end
    endtask

    // Request pulses separated by an idle cycle.
    task automatic rd_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            step(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    // Request held high for n consecutive cycles.
    task automatic rd_burst(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        seq = '0;
        do_reset(2);

        // Prefill: 31 words keep IDLE, the 32nd starts playback.
        wr(31);
        wr(1);
        idle(1);
        // Ordered drain of the 32 prefilled words.
        rd_pulses(32);
        // Underrun at level 0 in PLAY, then refill to leave UNDERRUN.
        rd_pulses(1);
        wr(32);
        idle(1);
        // Fill to full (watermark crossing at 48), then a rejected extra.
        wr(33);
        idle(1);
        // Read 10 / write 10 to wrap both pointers.
        rd_pulses(10);
        wr(10);
        rd_burst(44);
        // Simultaneous write and read at level 20.
        seq = seq + 1'b1;
        step(1'b1, 1'b1, seq, 1'b1);
        // Up to 40, then a one-cycle disable with a pending request.
        wr(20);
        seq = seq + 1'b1;
        step(1'b0, 1'b1, seq, 1'b1);
        idle(2);
        // Saturate the underrun counter.
        for (int k = 0; k < 256; k++) begin
            wr(32);
            idle(2);
            rd_burst(33);
        end

        // Randomized traffic in segments with varying bias.
        for (int s = 0; s < 40; s++) begin
            int pw, pr, pe;
            pw = $urandom_range(0, 100);
            pr = $urandom_range(0, 100);
            pe = (s % 8 == 7) ? 90 : 99;
            for (int c = 0; c < 100; c++) begin
                bit en, v, rq;
                en = ($urandom_range(0, 99) < pe);
                v  = ($urandom_range(0, 99) < pw);
                rq = ($urandom_range(0, 99) < pr);
                step(en, v, W'($urandom), rq);
            end
            if (s == 20) do_reset(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
